// File: rtl/router_pkg.sv
// Shared router definitions: flit width, one-hot output direction codes and
// flit header field layout, plus small helpers for reading header fields.
package router_pkg;

    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned DIR_WIDTH  = 5;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned RR_WIDTH   = 2;
    localparam int unsigned CNT_WIDTH  = 16;

    // One-hot output direction codes
    localparam logic [DIR_WIDTH-1:0] DIR_L  = 5'b00001;
    localparam logic [DIR_WIDTH-1:0] DIR_R  = 5'b00010;
    localparam logic [DIR_WIDTH-1:0] DIR_U  = 5'b00100;
    localparam logic [DIR_WIDTH-1:0] DIR_D  = 5'b01000;
    localparam logic [DIR_WIDTH-1:0] DIR_PE = 5'b10000;

    // Flit header field positions
    localparam int unsigned HDR_VALID_BIT = 63;
    localparam int unsigned HDR_RTYPE_HI  = 62;
    localparam int unsigned HDR_RTYPE_LO  = 61;
    localparam int unsigned HDR_DEST_HI   = 55;
    localparam int unsigned HDR_DEST_LO   = 48;

    // Flit layout as a packed payload
    typedef struct packed {
        logic        valid;
        logic [1:0]  rtype;
        logic [4:0]  rsvd;
        logic [7:0]  dest;
        logic [47:0] payload;
    } flit_t;

    // Destination field of a raw flit
    function automatic logic [7:0] flit_dest(input logic [DATA_WIDTH-1:0] flit);
        return flit[HDR_DEST_HI:HDR_DEST_LO];
    endfunction

    // Valid bit of a raw flit
    function automatic logic flit_valid(input logic [DATA_WIDTH-1:0] flit);
        return flit[HDR_VALID_BIT];
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
//   req   : request vector, bit i = requester i+1
//   ptr   : index of the highest-priority requester
//   en    : when low no grant is issued
//   grant : one-hot grant (or zero)
//   idx   : index of the winner (meaningful only when grant != 0)
module rr_arbiter4
    import router_pkg::*;
(
    input  logic [NUM_REQ-1:0]  req,
    input  logic [RR_WIDTH-1:0] ptr,
    input  logic                en,
    output logic [NUM_REQ-1:0]  grant,
    output logic [RR_WIDTH-1:0] idx
);

    logic                found;
    logic [RR_WIDTH-1:0] cand;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first active requester wins
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = RR_WIDTH'(ptr + RR_WIDTH'(i));
            if (en && !found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_interface.sv
// Per-direction output stage of the mesh router. Arbitrates round-robin among
// the four input interfaces that may target this direction, holds the winner
// in a one-flit buffer and hands it downstream over the so/ri handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   req_1..req_4        : one-hot route requests from input interfaces
//   datai_1..datai_4    : flits offered by the input interfaces
//   ri                  : downstream ready
//   so, datao           : registered valid flag and flit toward downstream
//   buf_clear_1..4      : combinational grant back to the winning input
//   tx_count            : registered count of delivered flits (wraps)
module output_interface
    import router_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter logic [DIR_WIDTH-1:0] DIRECTION  = DIR_L
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIR_WIDTH-1:0]  req_1,
    input  logic [DIR_WIDTH-1:0]  req_2,
    input  logic [DIR_WIDTH-1:0]  req_3,
    input  logic [DIR_WIDTH-1:0]  req_4,
    input  logic [DATA_WIDTH-1:0] datai_1,
    input  logic [DATA_WIDTH-1:0] datai_2,
    input  logic [DATA_WIDTH-1:0] datai_3,
    input  logic [DATA_WIDTH-1:0] datai_4,
    input  logic                  ri,
    output logic                  so,
    output logic [DATA_WIDTH-1:0] datao,
    output logic                  buf_clear_1,
    output logic                  buf_clear_2,
    output logic                  buf_clear_3,
    output logic                  buf_clear_4,
    output logic [CNT_WIDTH-1:0]  tx_count
);

    logic                  full;
    logic [DATA_WIDTH-1:0] out_buf;
    logic [RR_WIDTH-1:0]   rr;
    logic [CNT_WIDTH-1:0]  tx_cnt;

    logic [NUM_REQ-1:0]    active;
    logic [NUM_REQ-1:0]    grant;
    logic [RR_WIDTH-1:0]   win_idx;
    logic                  win;
    logic                  drain;
    logic                  can_accept;
    logic [DATA_WIDTH-1:0] win_data;

    // A requester is active only if it routes toward this direction
    assign active = {|(req_4 & DIRECTION), |(req_3 & DIRECTION),
                     |(req_2 & DIRECTION), |(req_1 & DIRECTION)};

    // Delivery happens at the edge where the buffer is full and downstream ready
    assign drain      = full & ri;
    assign can_accept = ~full | drain;

    rr_arbiter4 u_arb (
        .req   (active),
        .ptr   (rr),
        .en    (can_accept),
        .grant (grant),
        .idx   (win_idx)
    );

    assign win = |grant;

    // Datapath select of the winning flit
    always_comb begin
        win_data = datai_1;
        case (win_idx)
            2'd0: win_data = datai_1;
            2'd1: win_data = datai_2;
            2'd2: win_data = datai_3;
            2'd3: win_data = datai_4;
        endcase
    end

    // Buffer, handshake state, priority pointer and delivery counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 1'b0;
            out_buf <= '0;
            rr      <= '0;
            tx_cnt  <= '0;
        end else begin
            if (drain) begin
                tx_cnt <= tx_cnt + CNT_WIDTH'(1);
            end
            // A new winner overwrites a draining flit, giving one flit per cycle
            if (win) begin
                out_buf <= win_data;
                full    <= 1'b1;
                rr      <= RR_WIDTH'(win_idx + RR_WIDTH'(1));
            end else if (drain) begin
                full    <= 1'b0;
            end
        end
    end

    assign so       = full;
    assign datao    = out_buf;
    assign tx_count = tx_cnt;

    // Grants are forced low while reset is held
    assign buf_clear_1 = grant[0] & rst;
    assign buf_clear_2 = grant[1] & rst;
    assign buf_clear_3 = grant[2] & rst;
    assign buf_clear_4 = grant[3] & rst;

endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: directed literal checks plus a randomized phase,
// with a per-cycle comparison against a flit-level reference model.
module tb_output_interface;

    localparam logic [4:0] DIR = 5'b00001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  req_a [4];
    logic [63:0] dat_a [4];
    logic        ri = 1'b0;
    logic        so;
    logic [63:0] datao;
    logic        bc1, bc2, bc3, bc4;
    logic [15:0] tx_count;
    logic [3:0]  bc;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_full = 1'b0;
    logic [63:0] m_buf  = '0;
    int          m_rr   = 0;
    int          m_cnt  = 0;
    int          pend_win = -1;
    bit          pend_drain = 1'b0;
    int          exp_win;
    logic [3:0]  exp_gnt;

    assign bc = {bc4, bc3, bc2, bc1};

    always #5 clk = ~clk;

    output_interface #(.DATA_WIDTH(64), .DIRECTION(DIR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_1       (req_a[0]),
        .req_2       (req_a[1]),
        .req_3       (req_a[2]),
        .req_4       (req_a[3]),
        .datai_1     (dat_a[0]),
        .datai_2     (dat_a[1]),
        .datai_3     (dat_a[2]),
        .datai_4     (dat_a[3]),
        .ri          (ri),
        .so          (so),
        .datao       (datao),
        .buf_clear_1 (bc1),
        .buf_clear_2 (bc2),
        .buf_clear_3 (bc3),
        .buf_clear_4 (bc4),
        .tx_count    (tx_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < 4; k++) req_a[k] = 5'b0;
    endtask

    // Model: every negedge predict the grant and compare all outputs
    always @(negedge clk) begin
        exp_win = -1;
        if (rst && (!m_full || ri)) begin
            for (int i = 0; i < 4; i++) begin
                if (exp_win < 0 && (req_a[(m_rr + i) % 4] & DIR) != 5'b0)
                    exp_win = (m_rr + i) % 4;
            end
        end
        exp_gnt = (exp_win < 0) ? 4'b0 : 4'(1 << exp_win);
        check("model_so", {63'b0, so}, {63'b0, m_full});
        check("model_datao", datao, m_buf);
        check("model_tx_count", {48'b0, tx_count}, 64'(m_cnt % 65536));
        check("model_buf_clear", {60'b0, bc}, {60'b0, exp_gnt});
        pend_win   = exp_win;
        pend_drain = rst && m_full && ri;
    end

    // Model: apply the predicted transfer at the clock edge
    always @(posedge clk) begin
        if (rst) begin
            if (pend_drain) m_cnt = m_cnt + 1;
            if (pend_win >= 0) begin
                m_buf  = dat_a[pend_win];
                m_full = 1'b1;
                m_rr   = (pend_win + 1) % 4;
            end else if (pend_drain) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge rst) begin
        m_full = 1'b0;
        m_buf  = '0;
        m_rr   = 0;
        m_cnt  = 0;
        pend_win   = -1;
        pend_drain = 1'b0;
    end

    initial begin
        clear_reqs();
        for (int k = 0; k < 4; k++) dat_a[k] = 64'h0;

        // Reset held with inputs toggling
        repeat (4) begin
            step();
            for (int k = 0; k < 4; k++) begin
                req_a[k] = 5'($urandom);
                dat_a[k] = {$urandom, $urandom};
            end
            ri = 1'($urandom);
            #1;
            check("rst_so", {63'b0, so}, 64'd0);
            check("rst_datao", datao, 64'd0);
            check("rst_buf_clear", {60'b0, bc}, 64'd0);
            check("rst_tx_count", {48'b0, tx_count}, 64'd0);
        end
        rst = 1'b1;
        clear_reqs();
        ri = 1'b0;
        step();
        check("post_rst_so", {63'b0, so}, 64'd0);
        check("post_rst_tx", {48'b0, tx_count}, 64'd0);

        // Single flit
        req_a[0] = 5'b00001;
        dat_a[0] = 64'hC010_0000_1111_1111;
        ri = 1'b1;
        #1;
        check("single_grant", {60'b0, bc}, 64'b0001);
        step();
        req_a[0] = 5'b0;
        check("single_so", {63'b0, so}, 64'd1);
        check("single_datao", datao, 64'hC010_0000_1111_1111);
        step();
        check("single_tx", {48'b0, tx_count}, 64'd1);
        check("single_so_low", {63'b0, so}, 64'd0);

        // Non-matching direction
        req_a[1] = 5'b00010;
        dat_a[1] = 64'hDEAD_BEEF_0000_0002;
        #1;
        check("nomatch_grant", {60'b0, bc}, 64'd0);
        step();
        check("nomatch_so", {63'b0, so}, 64'd0);
        req_a[1] = 5'b0;

        // Fresh reset so the pointer starts at requester 1
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Round-robin with all four requesters active
        for (int k = 0; k < 4; k++) begin
            req_a[k] = 5'b00001;
            dat_a[k] = 64'h1000 + 64'(k + 1);
        end
        ri = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] rr_exp [5];
            rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            #1;
            check("rr_grant", {60'b0, bc}, {60'b0, rr_exp[i]});
            if (i > 0) begin
                check("rr_so", {63'b0, so}, 64'd1);
                check("rr_datao", datao, 64'h1000 + 64'(((i - 1) % 4) + 1));
                check("rr_tx", {48'b0, tx_count}, 64'(i - 1));
            end
            step();
        end

        // Backpressure: buffer holds requester 1's flit
        clear_reqs();
        req_a[2] = 5'b10001;
        dat_a[2] = 64'h3333_0000_ABCD_0003;
        ri = 1'b0;
        repeat (5) begin
            #1;
            check("bp_datao", datao, 64'h1001);
            check("bp_so", {63'b0, so}, 64'd1);
            check("bp_grant", {60'b0, bc}, 64'd0);
            step();
        end
        ri = 1'b1;
        #1;
        check("bp_release_grant", {60'b0, bc}, 64'b0100);
        step();
        req_a[2] = 5'b0;
        check("bp_release_datao", datao, 64'h3333_0000_ABCD_0003);
        check("bp_release_so", {63'b0, so}, 64'd1);
        step();
        check("bp_drained_so", {63'b0, so}, 64'd0);

        // Reset mid-operation
        req_a[1] = 5'b00001;
        dat_a[1] = 64'h5555_0000_0000_0055;
        ri = 1'b0;
        step();
        req_a[1] = 5'b0;
        check("mid_so_before", {63'b0, so}, 64'd1);
        req_a[3] = 5'b00001;
        rst = 1'b0;
        #1;
        check("mid_rst_so", {63'b0, so}, 64'd0);
        check("mid_rst_datao", datao, 64'd0);
        check("mid_rst_tx", {48'b0, tx_count}, 64'd0);
        check("mid_rst_grant", {60'b0, bc}, 64'd0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_a[k] = 5'b00001;
            dat_a[k] = 64'h7000 + 64'(k + 1);
        end
        ri = 1'b1;
        #1;
        check("mid_first_grant", {60'b0, bc}, 64'b0001);
        step();
        check("mid_first_datao", datao, 64'h7001);
        clear_reqs();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
            end
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: req_a[k] = 5'b0;
                    1: req_a[k] = DIR | 5'($urandom);
                    2: req_a[k] = 5'($urandom) & ~DIR;
                    default: req_a[k] = 5'($urandom);
                endcase
                dat_a[k] = {$urandom, $urandom};
            end
            ri = ($urandom_range(0, 9) < 7);
        end
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
